// File: rtl/myproject_mac_acc.sv
// Multiply-accumulate result stage: sums N_TERMS signed products plus a per-result bias,
// rescales by FRAC_SHIFT and presents a saturated 16-bit result under a valid/ready handshake.
`timescale 1ns/1ps
module myproject_mac_acc #(
  parameter int unsigned N_TERMS    = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned FRAC_SHIFT = 10
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic signed [25:0] prod_in,
  input  logic               prod_valid,
  output logic               prod_ready,
  input  logic signed [15:0] bias_in,
  input  logic               acc_clear,
  output logic signed [15:0] res_out,
  output logic               res_sat,
  output logic               res_valid,
  input  logic               res_ready
);

  localparam int unsigned CntW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_TERMS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = -(ACC_WIDTH'(32768));

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e                        state_q;
  logic        [CntW-1:0]        count_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [15:0]            res_out_q;
  logic                          res_sat_q;
  logic                          res_valid_q;

  logic                          accept;
  logic                          first_term;
  logic                          last_term;
  logic signed [ACC_WIDTH-1:0]   term_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [ACC_WIDTH-1:0]   acc_scaled;
  logic                          sat_hi;
  logic                          sat_lo;
  logic signed [15:0]            res_clip;

  assign prod_ready = (state_q == StAcc) && !acc_clear;
  assign accept     = prod_valid && prod_ready;
  assign first_term = (count_q == '0);
  assign last_term  = (count_q == LastCnt);

  always_comb begin
    term_ext   = {{(ACC_WIDTH - 26){prod_in[25]}}, prod_in};
    bias_ext   = {{(ACC_WIDTH - 16){bias_in[15]}}, bias_in} << FRAC_SHIFT;
    // Term 0 restarts the sum from the bias, so a stale acc never leaks into a new result.
    acc_sum    = first_term ? (bias_ext + term_ext) : (acc_q + term_ext);
    acc_scaled = acc_sum >>> FRAC_SHIFT;
    sat_hi     = (acc_scaled > SatMax);
    sat_lo     = (acc_scaled < SatMin);
    if (sat_hi) begin
      res_clip = 16'sh7fff;
    end else if (sat_lo) begin
      res_clip = -16'sh8000;
    end else begin
      res_clip = acc_scaled[15:0];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StAcc;
      count_q     <= '0;
      acc_q       <= '0;
      res_out_q   <= '0;
      res_sat_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (acc_clear) begin
            count_q <= '0;
          end else if (accept) begin
            acc_q <= acc_sum;
            if (last_term) begin
              count_q     <= '0;
              state_q     <= StHold;
              res_out_q   <= res_clip;
              res_sat_q   <= sat_hi || sat_lo;
              res_valid_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        StHold: begin
          // acc_clear is deliberately ignored here so a pending result is never lost.
          if (res_ready) begin
            state_q     <= StAcc;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign res_out   = res_out_q;
  assign res_sat   = res_sat_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_myproject_mac_acc.sv
// Directed self-checking bench for myproject_mac_acc with N_TERMS=4, FRAC_SHIFT=10.
`timescale 1ns/1ps
module tb_myproject_mac_acc;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic signed [25:0] prod_in;
  logic               prod_valid;
  logic               prod_ready;
  logic signed [15:0] bias_in;
  logic               acc_clear;
  logic signed [15:0] res_out;
  logic               res_sat;
  logic               res_valid;
  logic               res_ready;

  int n_checks = 0;
  int n_fails  = 0;

  myproject_mac_acc #(
    .N_TERMS   (4),
    .ACC_WIDTH (32),
    .FRAC_SHIFT(10)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .bias_in   (bias_in),
    .acc_clear (acc_clear),
    .res_out   (res_out),
    .res_sat   (res_sat),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Feed four back-to-back terms and check the result one cycle after the last accept.
  task automatic feed4(input string tag, input logic signed [25:0] v,
                       input logic signed [15:0] b, input logic signed [31:0] exp_res,
                       input logic exp_sat);
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1;
      prod_in    = v;
      bias_in    = b;
      #1;
      chk({tag, " prod_ready"}, 32'(prod_ready), 1);
      if (i == 3) chk({tag, " valid_before_last"}, 32'(res_valid), 0);
      tick();
    end
    prod_valid = 1'b0;
    prod_in    = '0;
    bias_in    = '0;
    #1;
    chk({tag, " res_valid"}, 32'(res_valid), 1);
    chk({tag, " res_out"}, 32'(res_out), exp_res);
    chk({tag, " res_sat"}, 32'(res_sat), 32'(exp_sat));
    chk({tag, " hold_ready"}, 32'(prod_ready), 0);
  endtask

  task automatic drain(input string tag);
    res_ready = 1'b1;
    tick();
    chk({tag, " drain_valid"}, 32'(res_valid), 0);
    chk({tag, " drain_ready"}, 32'(prod_ready), 1);
  endtask

  initial begin
    ap_rst     = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    bias_in    = '0;
    acc_clear  = 1'b0;
    res_ready  = 1'b1;
    #12;
    chk("rst res_out", 32'(res_out), 0);
    chk("rst res_sat", 32'(res_sat), 0);
    chk("rst res_valid", 32'(res_valid), 0);
    chk("rst prod_ready", 32'(prod_ready), 1);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    #1;

    feed4("basic", 26'sd1024, 16'sd0, 4, 1'b0);
    drain("basic");
    feed4("floor", -26'sd1, 16'sd0, -1, 1'b0);
    drain("floor");
    feed4("bias", 26'sd0, 16'sd3, 3, 1'b0);
    drain("bias");
    feed4("sat_pos", 26'sd33554431, 16'sd0, 32767, 1'b1);
    drain("sat_pos");
    feed4("sat_neg", -26'sd33554432, 16'sd0, -32768, 1'b1);
    drain("sat_neg");

    // Backpressure: result held for 5 cycles, products offered but refused, clear ignored.
    res_ready = 1'b0;
    feed4("hold", 26'sd2048, 16'sd0, 8, 1'b0);
    prod_valid = 1'b1;
    prod_in    = 26'sd9999;
    for (int i = 0; i < 5; i++) begin
      acc_clear = (i == 2);
      tick();
      chk("hold res_valid", 32'(res_valid), 1);
      chk("hold res_out", 32'(res_out), 8);
      chk("hold prod_ready", 32'(prod_ready), 0);
    end
    acc_clear  = 1'b0;
    prod_valid = 1'b0;
    drain("hold");
    feed4("after_hold", 26'sd1024, 16'sd0, 4, 1'b0);
    drain("after_hold");

    // Clear after two terms drops the product presented with it.
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_in    = 26'sd5000;
      tick();
    end
    acc_clear = 1'b1;
    prod_in   = 26'sd7777;
    #1;
    chk("clear prod_ready", 32'(prod_ready), 0);
    tick();
    acc_clear  = 1'b0;
    prod_valid = 1'b0;
    chk("clear no_result", 32'(res_valid), 0);
    feed4("after_clear", 26'sd256, 16'sd0, 1, 1'b0);
    drain("after_clear");

    // Asynchronous reset in the middle of a cycle after two terms.
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_in    = 26'sd3000;
      bias_in    = 16'sd5;
      tick();
    end
    prod_valid = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk("async res_out", 32'(res_out), 0);
    chk("async res_valid", 32'(res_valid), 0);
    chk("async prod_ready", 32'(prod_ready), 1);
    tick();
    ap_rst = 1'b0;
    #1;
    feed4("after_rst", 26'sd2048, 16'sd0, 8, 1'b0);
    drain("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
